fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the 32-bit, 1024-deep FIFO among N_REQ requesters.
- Arbitration is round-robin, with burst locking and an idle-timeout release.
- Drives the FIFO wr_en/wr_data directly and observes its full flag.
- Sits between producer engines and the FIFO. The FIFO read side is untouched.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DATA_W, 32: data width; matches the FIFO.
- MAX_BURST, 16: maximum beats per grant before forced release (1..256).
- TIMEOUT, 8: consecutive cycles the granted requester may hold req_valid low mid-burst before release (1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester last beat of burst; qualified by valid.
- req_data  in  N_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  per-requester beat accepted this cycle when valid&ready.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_W  FIFO write data.
- grant_valid  out  1  a requester currently holds the port.
- grant_id  out  clog2(N_REQ)  index of the holder; 0 when idle.
- beat_cnt  out  8  beats accepted in the current grant.

Behaviour:
- Reset (rst=0, async): state=ARB, grant_valid=0, grant_id=0, beat_cnt=0, idle counter=0, rr pointer=0 (requester 0 highest priority), req_ready=0, fifo_wr_en=0.
- States: ARB, BURST. Registered state, grant_id, beat_cnt, idle counter, rr pointer.
- ARB:
  - If any req_valid, select the first requester with valid set, searching from rr pointer upward and wrapping.
  - Register it as grant_id, set grant_valid=1, go to BURST next cycle.
  - No beats are accepted in ARB; grant latency is 1 cycle from req_valid.
  - With no requests, stay in ARB.
- BURST:
  - req_ready[grant_id] = !fifo_full. All other req_ready = 0.
  - Combinational: fifo_wr_en = req_valid[grant_id] & !fifo_full; fifo_wr_data = req_data of grant_id.
  - Accepted beat: beat_cnt+1, idle counter cleared.
- Release:
  - Occurs on the cycle of an accepted beat with req_last=1, or an accepted beat with beat_cnt==MAX_BURST-1.
  - Also occurs when the idle counter reaches TIMEOUT. The idle counter increments each BURST cycle with req_valid[grant_id]=0. Cycles with valid=1 but fifo_full=1 do not count toward the timeout.
  - On release: next state ARB, grant_valid=0, grant_id=0, beat_cnt=0, rr pointer=(released id+1) mod N_REQ.
  - A released requester cannot be regranted in the same cycle, so there is always ≥1 bubble cycle between grants.
- fifo_full back-pressure: beats stall with no loss or duplication. The grant is held indefinitely while valid stays high.
- fifo_wr_en is never asserted while fifo_full=1 or in ARB.
- Changing req_valid of non-granted requesters during BURST has no effect.
- Reset mid-burst: all state clears immediately. Any beat presented in that cycle is not written.

Test Plan:
- Single requester 2, burst of 5 beats 0xA0..0xA4 with last on beat 5 → grant_id=2 one cycle after valid; FIFO receives 0xA0..0xA4 in order; grant_valid drops the cycle after beat 5; rr pointer=3.
- All four requesters valid with 2-beat bursts after reset → grant order 0,1,2,3 with one ARB bubble between grants; 8 FIFO writes total.
- Requester 1 streams 20 beats, never asserting last, MAX_BURST=16 → release after 16th beat; requester 1 regranted only after other pending requesters; remaining 4 beats follow in order.
- fifo_full held high for 10 cycles mid-burst → fifo_wr_en=0 and req_ready=0 throughout; no timeout; beat_cnt unchanged; resumes with no lost or duplicated data.
- Granted requester 3 drops valid after 2 beats → release exactly 8 cycles later (TIMEOUT=8); requester 0 pending is granted next.
- rst asserted low for 1 cycle mid-burst → outputs zero asynchronously; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// A grant is held for a burst until last, MAX_BURST beats, or an idle timeout.
module fifo_wr_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 16,
  parameter  int TIMEOUT   = 8,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  output logic                    grant_valid,
  output logic [ID_W-1:0]         grant_id,
  output logic [7:0]              beat_cnt
);

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [7:0]      idle_cnt;

  logic [ID_W-1:0] pick_id;
  logic            pick_found;
  logic [ID_W-1:0] scan_id;
  logic            in_burst;
  logic            holder_valid;
  logic            holder_last;
  logic            accept;
  logic            release_beat;
  logic            release_idle;
  logic [ID_W-1:0] next_rr;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_id = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  assign in_burst     = (state == BURST);
  assign holder_valid = req_valid[grant_id];
  assign holder_last  = req_last[grant_id];
  assign accept       = in_burst & holder_valid & ~fifo_full;

  assign fifo_wr_en   = accept;
  assign fifo_wr_data = req_data[int'(grant_id)*DATA_W +: DATA_W];

  always_comb begin
    req_ready = '0;
    if (in_burst && !fifo_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // A stalled beat (valid high, FIFO full) neither advances nor idles the burst.
  assign release_beat = accept & (holder_last | (beat_cnt == 8'(MAX_BURST - 1)));
  assign release_idle = in_burst & ~holder_valid & (idle_cnt == 8'(TIMEOUT - 1));
  assign next_rr      = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        ARB: begin
          if (pick_found) begin
            state       <= BURST;
            grant_valid <= 1'b1;
            grant_id    <= pick_id;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
          end
        end
        BURST: begin
          if (release_beat || release_idle) begin
            state       <= ARB;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            beat_cnt    <= '0;
            idle_cnt    <= '0;
            rr_ptr      <= next_rr;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 8'd1;
            idle_cnt <= '0;
          end else if (!holder_valid) begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: begin
          state       <= ARB;
          grant_valid <= 1'b0;
          grant_id    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: per-requester data scoreboard plus a transaction-level
// reference of grant ownership, directed scenarios and randomized rounds.
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 16;
  localparam int TIMEOUT   = 8;
  localparam int FAIL_CAP  = 40;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [DATA_W-1:0]       fifo_wr_data;
  logic                    grant_valid;
  logic [1:0]              grant_id;
  logic [7:0]              beat_cnt;

  fifo_wr_arbiter #(
    .N_REQ    (N_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .beat_cnt    (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;

  // Stimulus sources (beats still to present) and expected FIFO stream per requester.
  logic [DATA_W-1:0] src_d [N_REQ][$];
  bit                src_l [N_REQ][$];
  logic [DATA_W-1:0] exp_q [N_REQ][$];
  int                grant_log [$];

  int unsigned      p_valid;
  int unsigned      p_full;
  bit               force_full;
  logic [N_REQ-1:0] en;

  // Reference ownership: holder -1 means nobody owns the port.
  int m_hold, m_prio, m_beats, m_idle;
  bit prev_gv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the reference, then advances the reference.
  always @(negedge clk) begin
    if (!rst) begin
      m_hold  = -1;
      m_prio  = 0;
      m_beats = 0;
      m_idle  = 0;
      prev_gv = 1'b0;
    end else begin
      int exp_gid;
      bit exp_gv;
      logic [N_REQ-1:0] exp_ready;
      bit exp_wr;
      logic [DATA_W-1:0] exp_d;
      bit found;
      exp_gv    = (m_hold >= 0);
      exp_gid   = exp_gv ? m_hold : 0;
      exp_ready = (exp_gv && !fifo_full) ? N_REQ'(1 << exp_gid) : '0;
      exp_wr    = exp_gv && req_valid[exp_gid] && !fifo_full;
      check("grant_valid", grant_valid, exp_gv);
      check("grant_id",    grant_id,    exp_gid);
      check("beat_cnt",    beat_cnt,    m_beats);
      check("req_ready",   req_ready,   exp_ready);
      check("fifo_wr_en",  fifo_wr_en,  exp_wr);
      if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_id));
      prev_gv = grant_valid;
      if (fifo_wr_en) begin
        n_writes++;
        if (exp_q[grant_id].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wr_data at %0t: got write %0h from requester %0d, want no write",
                   $time, fifo_wr_data, grant_id);
        end else begin
          exp_d = exp_q[grant_id].pop_front();
          check("wr_data", fifo_wr_data, exp_d);
        end
      end
      if (m_hold < 0) begin
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
          int j;
          j = (m_prio + k) % N_REQ;
          if (!found && req_valid[j]) begin
            found  = 1'b1;
            m_hold = j;
          end
        end
        m_beats = 0;
        m_idle  = 0;
      end else if (req_valid[m_hold] && !fifo_full) begin
        m_beats++;
        m_idle = 0;
        if (req_last[m_hold] || m_beats == MAX_BURST) begin
          m_prio  = (m_hold + 1) % N_REQ;
          m_hold  = -1;
          m_beats = 0;
        end
      end else if (!req_valid[m_hold]) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_prio  = (m_hold + 1) % N_REQ;
          m_hold  = -1;
          m_beats = 0;
          m_idle  = 0;
        end
      end
    end
  end

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
  endtask

  task automatic flush_queues();
    for (int i = 0; i < N_REQ; i++) begin
      src_d[i].delete();
      src_l[i].delete();
      exp_q[i].delete();
    end
  endtask

  task automatic load_burst(input int id, input int len, input bit with_last,
                            input bit fixed, input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] d;
    for (int k = 0; k < len; k++) begin
      d = fixed ? base + DATA_W'(k) : DATA_W'($urandom);
      src_d[id].push_back(d);
      src_l[id].push_back(with_last && (k == len - 1));
      exp_q[id].push_back(d);
    end
  endtask

  // One clock: note acceptances, then present the next beats after the edge.
  task automatic step();
    logic [N_REQ-1:0] acc;
    bit has;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i] && src_d[i].size() > 0) begin
        void'(src_d[i].pop_front());
        void'(src_l[i].pop_front());
      end
      has = (src_d[i].size() > 0);
      req_valid[i] = en[i] && has && ($urandom_range(99) < p_valid);
      req_last[i]  = has ? src_l[i][0] : 1'b0;
      req_data[i*DATA_W +: DATA_W] = has ? src_d[i][0] : '0;
    end
    fifo_full = force_full || ($urandom_range(99) < p_full);
  endtask

  function automatic bit all_sent();
    bit e;
    e = 1'b1;
    for (int i = 0; i < N_REQ; i++) if (src_d[i].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic run_until_idle(input string name, input int budget);
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!(all_sent() && !grant_valid) && c < budget && n_fail <= FAIL_CAP);
    if (c >= budget) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_budget: got %0d cycles without draining, want fewer", name, c);
    end
    for (int i = 0; i < N_REQ; i++) check({name, "_drained"}, exp_q[i].size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    flush_queues();
    @(posedge clk);
    #1;
    check("reset_grant_valid", grant_valid, 0);
    check("reset_grant_id",    grant_id,    0);
    check("reset_beat_cnt",    beat_cnt,    0);
    check("reset_req_ready",   req_ready,   0);
    check("reset_fifo_wr_en",  fifo_wr_en,  0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    grant_log.delete();
  endtask

  task automatic check_log(input string name, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({name, "_grants"}, grant_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < grant_log.size()) check({name, "_grant_order"}, grant_log[i], e[i]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    p_valid    = 100;
    p_full     = 0;
    force_full = 1'b0;
    en         = '1;
    do_reset();

    // Single requester 2, five beats 0xA0..0xA4.
    w0 = n_writes;
    load_burst(2, 5, 1'b1, 1'b1, 32'hA0);
    run_until_idle("t1", 200);
    check_log("t1", 1, 2, 0, 0, 0);
    check("t1_writes", n_writes - w0, 5);

    // All four requesters, two-beat bursts: strict 0,1,2,3 rotation.
    do_reset();
    w0 = n_writes;
    for (int i = 0; i < N_REQ; i++) load_burst(i, 2, 1'b1, 1'b0, '0);
    run_until_idle("t2", 200);
    check_log("t2", 4, 0, 1, 2, 3);
    check("t2_writes", n_writes - w0, 8);

    // Requester 1 streams 20 beats without last; forced release at MAX_BURST.
    do_reset();
    en = 4'b0010;
    load_burst(1, 20, 1'b0, 1'b1, 32'h1000);
    repeat (3) step();
    load_burst(0, 2, 1'b1, 1'b0, '0);
    load_burst(2, 2, 1'b1, 1'b0, '0);
    en = '1;
    run_until_idle("t3", 400);
    check_log("t3", 4, 1, 2, 0, 1);

    // FIFO full for 10 cycles mid-burst: stall only, no timeout.
    grant_log.delete();
    load_burst(0, 8, 1'b1, 1'b1, 32'h100);
    repeat (3) step();
    force_full = 1'b1;
    repeat (10) step();
    force_full = 1'b0;
    run_until_idle("t4", 200);
    check_log("t4", 1, 0, 0, 0, 0);

    // Requester 3 goes quiet after two beats; released after TIMEOUT idle cycles.
    do_reset();
    en = 4'b1000;
    load_burst(3, 2, 1'b0, 1'b0, '0);
    repeat (4) step();
    load_burst(0, 1, 1'b1, 1'b0, '0);
    en = '1;
    repeat (TIMEOUT - 1) step();
    check("t5_held_before_timeout", grant_valid, 1);
    step();
    check("t5_released_at_timeout", grant_valid, 0);
    run_until_idle("t5", 200);
    check_log("t5", 2, 3, 0, 0, 0);

    // Asynchronous reset mid-burst, then arbitration restarts at requester 0.
    grant_log.delete();
    load_burst(0, 10, 1'b1, 1'b0, '0);
    repeat (3) step();
    check("t6_in_burst", grant_valid, 1);
    #2;
    rst = 1'b0;
    flush_queues();
    #1;
    check("t6_async_grant_valid", grant_valid, 0);
    check("t6_async_wr_en",       fifo_wr_en,  0);
    check("t6_async_req_ready",   req_ready,   0);
    check("t6_async_beat_cnt",    beat_cnt,    0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    clear_inputs();
    grant_log.delete();
    load_burst(1, 2, 1'b1, 1'b0, '0);
    load_burst(0, 2, 1'b1, 1'b0, '0);
    run_until_idle("t6", 200);
    check_log("t6", 2, 0, 1, 0, 0);

    // Randomized rounds: random bursts, valid gaps and FIFO back-pressure.
    for (int r = 0; r < 8 && n_fail <= FAIL_CAP; r++) begin
      p_valid = 40 + $urandom_range(60);
      p_full  = $urandom_range(40);
      for (int i = 0; i < N_REQ; i++) begin
        int nb;
        nb = $urandom_range(2);
        for (int b = 0; b < nb; b++)
          load_burst(i, 1 + $urandom_range(24), ($urandom_range(2) != 0), 1'b0, '0);
      end
      run_until_idle("rand", 8000);
    end
    p_full = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
